cube_move_history: RTL and testbench

Parametrised move-history controller that sits between the cube driver's input FSM and the move engine. It records manual moves in a circular buffer and supports multi-level undo and redo. Each history entry holds only a compact move record, not the full 162-bit cube state. Every move the engine applies, whether forward, inverse for undo, or replayed for redo, is issued through one valid/ready output. It also keeps a saturating net move counter for the 7-segment display.

---
 rtl/cube_move_history.sv | 162 ++++++++++++++++
 tb/tb_cube_move_history.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_move_history.sv
// Move history for the cube engine: circular record buffer, undo/redo, net count.
// Optional redo support is compiled in with CUBE_HIST_REDO_EN.
module cube_move_history #(
  parameter int DEPTH   = 64,
  parameter int FACE_W  = 3,
  parameter int CNT_W   = 10,
  parameter int CNT_MAX = 999
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [FACE_W-1:0]       push_face,
  input  logic [1:0]              push_rot,
  input  logic                    undo_req,
  input  logic                    redo_req,
  output logic                    mv_valid,
  input  logic                    mv_ready,
  output logic [FACE_W-1:0]       mv_face,
  output logic [1:0]              mv_rot,
  output logic [CNT_W-1:0]        count,
  output logic [$clog2(DEPTH):0]  depth_used,
  output logic                    can_undo,
  output logic                    can_redo,
  output logic                    dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = FACE_W + 2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]       state;
  logic [PW-1:0]    base;
  logic [PW-1:0]    head;
  logic [PW-1:0]    head_m1;
  logic [PW-1:0]    head_p1;
  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    rd_undo;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_dec;
  logic             idle;
  logic             free;
  logic             do_push;
  logic             do_undo;
  logic             do_redo;
  logic             emit_done;
  logic             full;

  assign idle       = state == S_IDLE;
  assign push_ready = idle;
  assign head_m1    = head - PW'(1);
  assign head_p1    = head + PW'(1);
  assign depth_used = head - base;
  assign can_undo   = depth_used != '0;
  assign full       = depth_used == PW'(DEPTH);

  assign cnt_inc = (count == CNT_W'(CNT_MAX))
                 ? count : count + CNT_W'(1);
  assign cnt_dec = (count == '0)
                 ? count : count - CNT_W'(1);

  // A rot=0 push is still accepted, so it blocks undo/redo that cycle.
  assign free      = idle & ~clear & ~push_valid;
  assign do_push   = idle & ~clear & push_valid & (push_rot != 2'd0);
  assign do_undo   = free & undo_req & can_undo;
  assign emit_done = ~idle & ~clear & mv_ready;

  assign rd_undo = mem[head_m1[AW-1:0]];

`ifdef CUBE_HIST_REDO_EN
  logic [PW-1:0] top;
  logic [EW-1:0] rd_redo;

  assign rd_redo  = mem[head[AW-1:0]];
  assign can_redo = top != head;
  assign do_redo  = free & ~undo_req & redo_req & can_redo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      top <= '0;
    else if (clear)
      top <= '0;
    else if (do_push)
      top <= head_p1;
  end
`else
  logic redo_unused;

  assign redo_unused = redo_req;
  assign can_redo    = 1'b0;
  assign do_redo     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (do_push)
      mem[head[AW-1:0]] <= {push_face, push_rot};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      base     <= '0;
      head     <= '0;
      count    <= '0;
      mv_valid <= 1'b0;
      mv_face  <= '0;
      mv_rot   <= '0;
      dropped  <= 1'b0;
    end else if (clear) begin
      state    <= S_IDLE;
      base     <= '0;
      head     <= '0;
      count    <= '0;
      mv_valid <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      dropped <= 1'b0;
      unique case (1'b1)
        do_push: begin
          head     <= head_p1;
          count    <= cnt_inc;
          mv_face  <= push_face;
          mv_rot   <= push_rot;
          mv_valid <= 1'b1;
          state    <= S_EMIT;
          if (full) begin
            base    <= base + PW'(1);
            dropped <= 1'b1;
          end
        end
        do_undo: begin
          head     <= head_m1;
          count    <= cnt_dec;
          mv_face  <= rd_undo[EW-1:2];
          mv_rot   <= 2'd0 - rd_undo[1:0];
          mv_valid <= 1'b1;
          state    <= S_EMIT;
        end
`ifdef CUBE_HIST_REDO_EN
        do_redo: begin
          head     <= head_p1;
          count    <= cnt_inc;
          mv_face  <= rd_redo[EW-1:2];
          mv_rot   <= rd_redo[1:0];
          mv_valid <= 1'b1;
          state    <= S_EMIT;
        end
`endif
        emit_done: begin
          mv_valid <= 1'b0;
          state    <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_move_history.sv
// Bench for cube_move_history: vector table, scoreboard on emitted moves,
// hand sequences for stall/clear, async reset and counter saturation.
module tb_cube_move_history;

`ifdef CUBE_HIST_REDO_EN
  localparam bit REDO = 1'b1;
`else
  localparam bit REDO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       push_valid = 1'b0;
  logic [2:0] push_face = '0;
  logic [1:0] push_rot = '0;
  logic       undo_req = 1'b0;
  logic       redo_req = 1'b0;
  logic       mv_ready = 1'b1;

  logic       a_push_ready, a_mv_valid;
  logic [2:0] a_mv_face;
  logic [1:0] a_mv_rot;
  logic [9:0] a_count;
  logic [2:0] a_depth_used;
  logic       a_can_undo, a_can_redo, a_dropped;

  logic       b_push_ready, b_mv_valid;
  logic [2:0] b_mv_face;
  logic [1:0] b_mv_rot;
  logic [9:0] b_count;
  logic [3:0] b_depth_used;
  logic       b_can_undo, b_can_redo, b_dropped;

  always #5 clk = ~clk;

  cube_move_history #(.DEPTH(4), .CNT_MAX(999)) u_a (
    .clk(clk), .rst(rst), .clear(clear),
    .push_valid(push_valid), .push_ready(a_push_ready),
    .push_face(push_face), .push_rot(push_rot),
    .undo_req(undo_req), .redo_req(redo_req),
    .mv_valid(a_mv_valid), .mv_ready(mv_ready),
    .mv_face(a_mv_face), .mv_rot(a_mv_rot),
    .count(a_count), .depth_used(a_depth_used),
    .can_undo(a_can_undo), .can_redo(a_can_redo),
    .dropped(a_dropped)
  );

  cube_move_history #(.DEPTH(8), .CNT_MAX(3)) u_b (
    .clk(clk), .rst(rst), .clear(clear),
    .push_valid(push_valid), .push_ready(b_push_ready),
    .push_face(push_face), .push_rot(push_rot),
    .undo_req(undo_req), .redo_req(redo_req),
    .mv_valid(b_mv_valid), .mv_ready(mv_ready),
    .mv_face(b_mv_face), .mv_rot(b_mv_rot),
    .count(b_count), .depth_used(b_depth_used),
    .can_undo(b_can_undo), .can_redo(b_can_redo),
    .dropped(b_dropped)
  );

  typedef enum logic [2:0] {
    OP_PUSH, OP_UNDO, OP_REDO, OP_CLR, OP_PU
  } op_t;

  typedef struct {
    op_t        op;
    logic [2:0] f;
    logic [1:0] r;
    logic       emit;
    logic [2:0] ef;
    logic [1:0] er;
    logic [9:0] cnt;
    logic [2:0] du;
    logic       cu;
    logic       cr;
    logic       drp;
  } vec_t;

  typedef struct {
    logic [2:0] f;
    logic [1:0] r;
  } mv_t;

  vec_t vt[$];
  mv_t  sb[$];
  int   total = 0;
  int   bad = 0;

  function automatic vec_t mk(
    op_t op, int f, int r, bit emit, int ef, int er,
    int cnt, int du, bit cu, bit cr, bit drp);
    vec_t v;
    v.op = op; v.f = 3'(f); v.r = 2'(r);
    v.emit = emit; v.ef = 3'(ef); v.er = 2'(er);
    v.cnt = 10'(cnt); v.du = 3'(du);
    v.cu = cu; v.cr = cr; v.drp = drp;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input op_t op,
                       input logic [2:0] f,
                       input logic [1:0] r);
    @(posedge clk); #1;
    case (op)
      OP_PUSH: begin
        push_valid = 1'b1; push_face = f; push_rot = r;
      end
      OP_UNDO: undo_req = 1'b1;
      OP_REDO: redo_req = 1'b1;
      OP_CLR:  clear = 1'b1;
      OP_PU: begin
        push_valid = 1'b1; push_face = f; push_rot = r;
        undo_req = 1'b1;
      end
      default: ;
    endcase
    @(posedge clk); #1;
    push_valid = 1'b0;
    undo_req = 1'b0;
    redo_req = 1'b0;
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [2:0] f,
                          input logic [1:0] r);
    mv_t m;
    m.f = f; m.r = r;
    sb.push_back(m);
  endtask

  // Scoreboard: a move seen with valid&ready is consumed at the next edge.
  always @(negedge clk) begin : mon
    mv_t e;
    if (rst && a_mv_valid && mv_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_mv: got f=%0d r=%0d want none",
                 a_mv_face, a_mv_rot);
      end else begin
        e = sb.pop_front();
        if ({a_mv_face, a_mv_rot} !== {e.f, e.r}) begin
          bad++;
          $display("FAIL mv_out: got f=%0d r=%0d want f=%0d r=%0d",
                   a_mv_face, a_mv_rot, e.f, e.r);
        end
      end
    end
  end

  initial begin
    vec_t v;
    int   sc;

    vt.push_back(mk(OP_PUSH, 2, 1, 1, 2, 1, 1, 1, 1, 0, 0));
    vt.push_back(mk(OP_CLR,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_PUSH, 0, 1, 1, 0, 1, 1, 1, 1, 0, 0));
    vt.push_back(mk(OP_PUSH, 1, 2, 1, 1, 2, 2, 2, 1, 0, 0));
    vt.push_back(mk(OP_PUSH, 4, 3, 1, 4, 3, 3, 3, 1, 0, 0));
    vt.push_back(mk(OP_UNDO, 0, 0, 1, 4, 1, 2, 2, 1, REDO, 0));
    vt.push_back(mk(OP_UNDO, 0, 0, 1, 1, 2, 1, 1, 1, REDO, 0));
    vt.push_back(mk(OP_UNDO, 0, 0, 1, 0, 3, 0, 0, 0, REDO, 0));
    vt.push_back(mk(OP_UNDO, 0, 0, 0, 0, 0, 0, 0, 0, REDO, 0));
    vt.push_back(mk(OP_CLR,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(OP_PUSH, 5, 1, 1, 5, 1, 1, 1, 1, 0, 0));
    vt.push_back(mk(OP_UNDO, 0, 0, 1, 5, 3, 0, 0, 0, REDO, 0));
    vt.push_back(mk(OP_REDO, 0, 0, REDO, 5, 1,
                    int'(REDO), int'(REDO), REDO, 0, 0));
    vt.push_back(mk(OP_UNDO, 0, 0, REDO, 5, 3, 0, 0, 0, REDO, 0));
    vt.push_back(mk(OP_PUSH, 3, 1, 1, 3, 1, 1, 1, 1, 0, 0));
    vt.push_back(mk(OP_REDO, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    vt.push_back(mk(OP_CLR,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++)
      vt.push_back(mk(OP_PUSH, i, 1, 1, i, 1, i + 1,
                      (i < 4) ? i + 1 : 4, 1, 0, i >= 4));
    for (int j = 0; j < 4; j++)
      vt.push_back(mk(OP_UNDO, 0, 0, 1, 5 - j, 3, 5 - j,
                      3 - j, j != 3, REDO, 0));
    vt.push_back(mk(OP_UNDO, 0, 0, 0, 0, 0, 2, 0, 0, REDO, 0));
    vt.push_back(mk(OP_PU,   2, 2, 1, 2, 2, 3, 1, 1, 0, 0));
    vt.push_back(mk(OP_PUSH, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0));

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_push_ready", a_push_ready, 1);
    chk("rst_mv_valid", a_mv_valid, 0);
    chk("rst_mv_face", a_mv_face, 0);
    chk("rst_mv_rot", a_mv_rot, 0);
    chk("rst_count", a_count, 0);
    chk("rst_depth", a_depth_used, 0);
    chk("rst_can_undo", a_can_undo, 0);
    chk("rst_can_redo", a_can_redo, 0);
    chk("rst_dropped", a_dropped, 0);

    for (int k = 0; k < vt.size(); k++) begin
      v = vt[k];
      if (v.emit) push_exp(v.ef, v.er);
      apply(v.op, v.f, v.r);
      chk($sformatf("v%0d_mv_valid", k), a_mv_valid, v.emit);
      chk($sformatf("v%0d_count", k), a_count, v.cnt);
      chk($sformatf("v%0d_depth", k), a_depth_used, v.du);
      chk($sformatf("v%0d_can_undo", k), a_can_undo, v.cu);
      chk($sformatf("v%0d_can_redo", k), a_can_redo, v.cr);
      chk($sformatf("v%0d_dropped", k), a_dropped, v.drp);
    end

    // Stall: push held with mv_ready low; undo must be ignored.
    @(posedge clk); #1;
    mv_ready = 1'b0;
    push_valid = 1'b1; push_face = 3'd1; push_rot = 2'd3;
    @(posedge clk); #1;
    push_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", i), a_mv_valid, 1);
      chk($sformatf("stall%0d_face", i), a_mv_face, 1);
      chk($sformatf("stall%0d_rot", i), a_mv_rot, 3);
      chk($sformatf("stall%0d_pready", i), a_push_ready, 0);
      @(posedge clk); #1;
      undo_req = (i == 1);
    end
    undo_req = 1'b0;
    @(negedge clk);
    chk("stall_count", a_count, 4);
    chk("stall_depth", a_depth_used, 2);
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("clr_emit_valid", a_mv_valid, 0);
    chk("clr_emit_count", a_count, 0);
    chk("clr_emit_depth", a_depth_used, 0);
    mv_ready = 1'b1;

    // Saturation on the CNT_MAX=3 instance.
    for (int i = 0; i < 5; i++) begin
      push_exp(3'(i), 2'd2);
      apply(OP_PUSH, 3'(i), 2'd2);
      sc = (i < 3) ? i + 1 : 3;
      chk($sformatf("sat%0d_b_count", i), b_count, sc);
    end
    chk("sat_a_count", a_count, 5);
    chk("sat_b_depth", b_depth_used, 5);

    // Asynchronous reset while a move is pending.
    @(posedge clk); #1;
    mv_ready = 1'b0;
    push_valid = 1'b1; push_face = 3'd2; push_rot = 2'd1;
    @(posedge clk); #1;
    push_valid = 1'b0;
    #2 chk("pre_rst_valid", a_mv_valid, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", a_mv_valid, 0);
    chk("async_rst_count", a_count, 0);
    chk("async_rst_pready", a_push_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    mv_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
